// File: rtl/symbol_deframer.sv
// QPSK dibit deframer: packs FRAME_SYMS dibits MSB-first into bytes and queues them on a valid/ready byte stream.
// Optional descrambler (x^7+x^6+1 LFSR, seeded per frame) is enabled by defining DEFRAMER_DESCRAMBLE_EN.
module symbol_deframer #(
  parameter int FRAME_SYMS   = 63,
  parameter int IDLE_TIMEOUT = 64,
  parameter int FIFO_DEPTH   = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [1:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_last,
  input  logic        out_ready,
  output logic        frame_abort,
  output logic        overflow,
  output logic [15:0] frame_cnt
);

  localparam int SYM_W  = (FRAME_SYMS > 4) ? $clog2(FRAME_SYMS) : 2;
  localparam int IDLE_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int PTR_W  = AW + 1;

  typedef enum logic [0:0] {IDLE, COLLECT} state_t;

  state_t            state, state_next;
  logic [SYM_W-1:0]  sym_cnt, cur_idx;
  logic [IDLE_W-1:0] idle_cnt;
  logic [7:0]        byte_acc, byte_new;
  logic [1:0]        slot, dibit_eff;
  logic              last_sym, push, push_last, abort_now;

  logic [8:0]        mem [FIFO_DEPTH];
  logic [8:0]        head;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              empty, full, pop, wr_en;

  assign in_ready = ~rst;

`ifdef DEFRAMER_DESCRAMBLE_EN
  // The first dibit of a frame uses the seed directly; the register holds the state for the next dibit.
  logic [6:0] lfsr, lfsr_cur, lfsr_mid, lfsr_nxt;

  always_comb begin
    lfsr_cur  = (state == IDLE) ? 7'h7F : lfsr;
    lfsr_mid  = {lfsr_cur[5:0], lfsr_cur[6] ^ lfsr_cur[5]};
    lfsr_nxt  = {lfsr_mid[5:0], lfsr_mid[6] ^ lfsr_mid[5]};
    dibit_eff = in_data ^ {lfsr_cur[6], lfsr_mid[6]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= 7'h7F;
    end else if (in_valid) begin
      lfsr <= lfsr_nxt;
    end
  end
`else
  assign dibit_eff = in_data;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_next = last_sym ? IDLE : COLLECT;
        end
      end
      COLLECT: begin
        if (in_valid) begin
          state_next = last_sym ? IDLE : COLLECT;
        end else if (abort_now) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Symbol index of the incoming dibit decides its slot in the byte and whether the byte is complete.
  always_comb begin
    cur_idx  = (state == IDLE) ? '0 : sym_cnt;
    slot     = cur_idx[1:0];
    last_sym = (cur_idx == SYM_W'(FRAME_SYMS - 1));
    byte_new = (slot == 2'd0) ? 8'h00 : byte_acc;
    case (slot)
      2'd0:    byte_new[7:6] = dibit_eff;
      2'd1:    byte_new[5:4] = dibit_eff;
      2'd2:    byte_new[3:2] = dibit_eff;
      default: byte_new[1:0] = dibit_eff;
    endcase
    push      = in_valid & ((slot == 2'd3) | last_sym);
    push_last = in_valid & last_sym;
    abort_now = (state == COLLECT) & ~in_valid &
                (idle_cnt == IDLE_W'(IDLE_TIMEOUT - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sym_cnt     <= '0;
      idle_cnt    <= '0;
      byte_acc    <= 8'h00;
      frame_abort <= 1'b0;
    end else begin
      frame_abort <= abort_now;
      if (in_valid) begin
        sym_cnt  <= cur_idx + SYM_W'(1);
        idle_cnt <= '0;
        byte_acc <= byte_new;
      end else if (state == COLLECT && !abort_now) begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
      end
    end
  end

  // A full FIFO still accepts a push when the head is popped in the same cycle.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = ~empty & out_ready;
  assign wr_en = push & (~full | pop);
  assign head  = mem[rd_ptr[AW-1:0]];

  assign out_valid = ~empty;
  assign out_data  = empty ? 8'h00 : head[7:0];
  assign out_last  = ~empty & head[8];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= {push_last, byte_new};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      frame_cnt <= 16'h0000;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && full && !pop) begin
        overflow <= 1'b1;
      end
      if (wr_en && push_last) begin
        frame_cnt <= frame_cnt + 16'h0001;
      end
    end
  end

endmodule
